// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write-port arbiter for a shared load-enabled register
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   req      per-requester write request
//   lock     per-requester request to hold ownership past the grant cycle
//   din      write data, requester i on din[i*N +: N]
//   gnt      registered one-hot grant
//   reg_in   data of the granted requester, 0 when nothing is granted
//   reg_load load enable to the shared register
//   busy     high while a requester owns the port
module reg_write_arbiter #(
    parameter int N       = 16,
    parameter int NREQ    = 4,
    parameter int MAXLOCK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] lock,
    input  logic [NREQ*N-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic [N-1:0]    reg_in,
    output logic            reg_load,
    output logic            busy
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAXLOCK) + 1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    logic [1:0]    state;
    logic [PW-1:0] ptr, owner, win;
    logic [CW-1:0] lock_cnt;
    logic          found, lock_own, arb;
    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) owner = PW'(i);
    end
    // Descending scan so the requester closest to ptr is the last one assigned.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % NREQ);
            end
    end
    assign lock_own = |gnt && lock[owner];
    assign arb = (state == IDLE) || (state == GRANT && !lock_own) ||
                 (state == LOCKED && (!lock_own || lock_cnt == CW'(MAXLOCK - 1)));
    assign busy     = state != IDLE;
    assign reg_load = state == GRANT ? 1'b1 : state == LOCKED ? req[owner] : 1'b0;
    assign reg_in   = |gnt ? din[int'(owner)*N +: N] : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            lock_cnt <= '0;
        end else if (arb) begin
            state <= found ? GRANT : IDLE;
            gnt   <= found ? NREQ'(1) << win : '0;
            if (found) ptr <= PW'((int'(win) + 1) % NREQ);
        end else if (state == GRANT) begin
            state    <= LOCKED;
            lock_cnt <= '0;
        end else begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end
endmodule
